// File: rtl/popcount_ctrl_pkg.sv
// Shared definitions for the popcount sequencer.
//   pc_state_e : controller states (IDLE, RUN, DRAIN, DONE)
//   WORD_W     : data word width fed to the popcount datapath
//   POPCNT_W   : width of a single-word popcount (0..64)
package popcount_ctrl_pkg;

  localparam int WORD_W   = 64;
  localparam int POPCNT_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pc_state_e;

endpackage

// File: rtl/popcount_int64.sv
// Combinational population count datapath.
//   i_data  : input vector, WIDTH bits
//   o_count : number of set bits in i_data
// IMPL_TYPE 0 is a flat bit-serial adder chain; any other value sums
// per-byte counts, which gives a shallower adder tree.
module popcount_int64 #(
  parameter  int WIDTH     = 64,
  parameter  int IMPL_TYPE = 0,
  localparam int OUT_W     = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [OUT_W-1:0] o_count
);

  function automatic logic [3:0] pop8(input logic [7:0] b);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + {3'b000, b[i]};
    end
    return s;
  endfunction

  generate
    if (IMPL_TYPE == 0) begin : g_flat
      always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
          o_count = o_count + OUT_W'(i_data[i]);
        end
      end
    end else begin : g_bytes
      localparam int NB = (WIDTH + 7) / 8;
      localparam int PW = NB * 8;

      // Pad to a whole number of bytes; the pad bits are zero.
      logic [PW-1:0] w_padded;
      logic [3:0]    w_byte_cnt [NB];

      assign w_padded = PW'(i_data);

      for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        assign w_byte_cnt[gi] = pop8(w_padded[gi*8 +: 8]);
      end

      always_comb begin
        o_count = '0;
        for (int i = 0; i < NB; i++) begin
          o_count = o_count + OUT_W'(w_byte_cnt[i]);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/popcount_seq_ctrl.sv
// Multi-word popcount sequencer.
// Accepts a job (word count), streams 64-bit words through the popcount
// datapath, registers each word's count, accumulates them and presents
// the job total on a valid/ready result port.
//   clk, rst            : clock, asynchronous active-high reset
//   cmd_valid/ready/len : job command (len saturated to MAX_WORDS)
//   flush               : synchronous abort of the current job
//   data_valid/ready    : 64-bit data word stream
//   res_valid/ready     : job result, res_count = total set bits
//   busy                : high whenever not IDLE
// Every output is either a state decode or a register, so no valid
// input ever reaches a ready output combinationally.
module popcount_seq_ctrl
  import popcount_ctrl_pkg::*;
#(
  parameter int IMPL_TYPE = 0,
  parameter int MAX_WORDS = 256,
  parameter int LEN_W     = $clog2(MAX_WORDS + 1),
  parameter int CNT_W     = $clog2(MAX_WORDS * 64 + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              flush,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [WORD_W-1:0] data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              busy
);

  pc_state_e               r_state;
  pc_state_e               w_state_next;
  logic [LEN_W-1:0]        r_remaining;
  logic [POPCNT_W-1:0]     r_stage_pc;
  logic                    r_stage_v;
  logic [CNT_W-1:0]        r_acc;

  logic [POPCNT_W-1:0]     w_pc;
  logic [LEN_W-1:0]        w_len_sat;
  logic                    w_cmd_hs;
  logic                    w_data_hs;

  popcount_int64 #(
    .WIDTH     (WORD_W),
    .IMPL_TYPE (IMPL_TYPE)
  ) u_popcount (
    .i_data  (data),
    .o_count (w_pc)
  );

  // flush blocks both handshakes; in IDLE this is what gives it priority
  // over a pending command.
  assign w_cmd_hs  = cmd_valid  & cmd_ready  & ~flush;
  assign w_data_hs = data_valid & data_ready & ~flush;
  assign w_len_sat = (cmd_len > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : cmd_len;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (cmd_valid) w_state_next = (cmd_len == '0) ? DONE : RUN;
        RUN:     if (data_valid && (r_remaining == LEN_W'(1))) w_state_next = DRAIN;
        DRAIN:   w_state_next = DONE;
        DONE:    if (res_ready) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    cmd_ready  = (r_state == IDLE);
    data_ready = (r_state == RUN);
    res_valid  = (r_state == DONE);
    busy       = (r_state != IDLE);
  end

  assign res_count = r_acc;

  // Down-counter, stage register and accumulator.
  // DRAIN exists so the staged count of the last word lands in r_acc
  // before the result is shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining <= '0;
      r_stage_pc  <= '0;
      r_stage_v   <= 1'b0;
      r_acc       <= '0;
    end else if (flush && (r_state != IDLE)) begin
      r_remaining <= '0;
      r_stage_v   <= 1'b0;
      r_acc       <= '0;
    end else begin
      r_stage_v <= w_data_hs;
      if (w_data_hs) begin
        r_stage_pc  <= w_pc;
        r_remaining <= r_remaining - LEN_W'(1);
      end
      if (w_cmd_hs) begin
        r_remaining <= w_len_sat;
        r_acc       <= '0;
      end else if (r_stage_v) begin
        r_acc <= r_acc + CNT_W'(r_stage_pc);
      end
    end
  end

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
module tb_popcount_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_len;
  logic        flush;
  logic        data_valid;
  logic        data_ready;
  logic [63:0] data;
  logic        res_valid;
  logic        res_ready;
  logic [14:0] res_count;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  popcount_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .flush      (flush),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data       (data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_count  (res_count),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_cmd(input int len);
    int k;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_len   = len[8:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("cmd  len=%0d", len);
  endtask

  task automatic send_word(input logic [63:0] w, input int gap);
    int k;
    repeat (gap) @(negedge clk);
    data       = w;
    data_valid = 1'b1;
    k = 0;
    while (!data_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("data_ready_wait", data_ready, 1);
    @(negedge clk);
    data_valid = 1'b0;
    $display("word data=%h", w);
  endtask

  // Offer the same word every cycle until the result appears.
  task automatic stream(input logic [63:0] w, output int accepted);
    int k;
    data       = w;
    data_valid = 1'b1;
    accepted   = 0;
    k = 0;
    while (!res_valid && k < 600) begin
      if (data_ready) accepted++;
      @(negedge clk);
      k++;
    end
    data_valid = 1'b0;
    chk("stream_res_valid", res_valid, 1);
    $display("stream accepted=%0d", accepted);
  endtask

  task automatic get_res(input string tag, input int exp);
    int k;
    k = 0;
    while (!res_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_res_valid"}, res_valid, 1);
    chk({tag, "_cmd_ready_in_done"}, cmd_ready, 0);
    chk({tag, "_res_count"}, res_count, exp);
    $display("result %s count=%0d", tag, res_count);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_res_valid_after"}, res_valid, 0);
    chk({tag, "_idle_after"}, cmd_ready, 1);
  endtask

  initial begin
    int acc_words;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_len    = '0;
    flush      = 1'b0;
    data_valid = 1'b0;
    data       = '0;
    res_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single all-ones word, exact latency
    do_cmd(1);
    chk("t1_data_ready_after_cmd", data_ready, 1);
    chk("t1_busy", busy, 1);
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 0);
    chk("t1_drain_data_ready", data_ready, 0);
    chk("t1_drain_res_valid", res_valid, 0);
    @(negedge clk);
    chk("t1_res_valid_t2", res_valid, 1);
    get_res("t1", 64);

    // Four words with gaps: 1 + 2 + 4 + 1
    do_cmd(4);
    send_word(64'h1, 2);
    send_word(64'h3, 2);
    send_word(64'hF0, 2);
    send_word(64'h8000_0000_0000_0000, 2);
    chk("t2_drain_data_ready", data_ready, 0);
    chk("t2_drain_busy", busy, 1);
    get_res("t2", 8);

    // Zero-length job
    do_cmd(0);
    chk("t3_zero_res_valid", res_valid, 1);
    chk("t3_zero_res_count", res_count, 0);
    chk("t3_zero_data_ready", data_ready, 0);
    get_res("t3z", 0);

    // Oversized length saturates to 256 words
    do_cmd(300);
    stream(64'h1, acc_words);
    chk("t3_sat_words", acc_words, 256);
    get_res("t3s", 256);

    // Max job, result held 5 cycles, command offered with result handshake
    do_cmd(256);
    stream(64'hFFFF_FFFF_FFFF_FFFF, acc_words);
    chk("t4_words", acc_words, 256);
    chk("t4_res_count", res_count, 16384);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", res_valid, 1);
      chk("t4_hold_count", res_count, 16384);
    end
    $display("result t4 count=%0d", res_count);
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_len   = 9'd0;
    @(negedge clk);
    res_ready = 1'b0;
    chk("t4_no_cmd_in_res_cycle", res_valid, 0);
    chk("t4_idle_after_res", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t4_next_cmd_accepted", res_valid, 1);
    get_res("t4n", 0);

    // Flush after 3 of 10 words
    do_cmd(10);
    send_word(64'hFFFF, 0);
    send_word(64'hFFFF, 0);
    send_word(64'hFFFF, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5_flush_idle", cmd_ready, 1);
    chk("t5_flush_busy", busy, 0);
    chk("t5_flush_res_valid", res_valid, 0);
    chk("t5_flush_acc", res_count, 0);
    repeat (3) @(negedge clk);
    chk("t5_no_result", res_valid, 0);
    $display("flush done");
    do_cmd(1);
    send_word(64'hA, 0);
    get_res("t5", 2);

    // Asynchronous reset between edges while in RUN
    do_cmd(5);
    send_word(64'hFF, 0);
    send_word(64'hFF, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_cmd_ready", cmd_ready, 1);
    chk("t6_rst_data_ready", data_ready, 0);
    chk("t6_rst_res_valid", res_valid, 0);
    chk("t6_rst_res_count", res_count, 0);
    chk("t6_rst_busy", busy, 0);
    $display("async reset applied");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_cmd(2);
    send_word(64'hFF, 0);
    send_word(64'h0F0F, 0);
    get_res("t6", 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
